// File: rtl/bus_terminal_pkg.sv
// Shared constants and helpers for the bus terminal FIFO endpoint.
package bus_terminal_pkg;

  localparam int ID_W    = 8;
  localparam int PKT_MAX = 256;
  localparam logic [ID_W-1:0] BC_ID = 8'hFF;

  // Packets are zero-extended to PKT_MAX so one helper serves any packet width.
  function automatic logic [ID_W-1:0] dest_of(input logic [PKT_MAX-1:0] pkt,
                                              input int pkt_w);
    return pkt[pkt_w-1 -: ID_W];
  endfunction

endpackage

// File: rtl/bus_term_fifo.sv
// Synchronous FIFO with first-word fall-through head; callers pass already-qualified
// wr/rd strobes (never write when full without a read, never read when empty).
module bus_term_fifo #(
  parameter int width = 16,
  parameter int depth = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr,
  input  logic [width-1:0]             wr_data,
  input  logic                         rd,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(depth+1)-1:0]   count,
  output logic [width-1:0]             head
);

  localparam int PW = $clog2(depth);
  localparam int CW = $clog2(depth+1);

  logic [width-1:0] mem [depth];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + PW'(1);
      if (rd) rd_ptr <= rd_ptr + PW'(1);
      case ({wr, rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; validity is tracked by count, and
  // leaving it out of reset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= wr_data;
  end

  assign full  = (count == CW'(depth));
  assign empty = (count == '0);
  // Unwritten storage is never exposed: an empty FIFO shows zero.
  assign head  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/bus_terminal_fifo.sv
// Terminal endpoint for the bus controller: host-loaded TX FIFO drained by the bus,
// RX FIFO filled by the bus and drained by the host. Define ADDR_CHECK_EN to filter RX by destination ID.
module bus_terminal_fifo
  import bus_terminal_pkg::*;
#(
  parameter int              pckg_sz = 16,
  parameter int              depth   = 8,
  parameter logic [ID_W-1:0] id      = 8'h00,
  parameter logic [ID_W-1:0] bc      = BC_ID
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         tx_wr,
  input  logic [pckg_sz-1:0]           tx_data,
  output logic                         tx_full,
  output logic                         tx_ovf,
  output logic                         pndng,
  output logic [pckg_sz-1:0]           D_pop,
  input  logic                         pop,
  output logic                         tx_unf,
  input  logic                         push,
  input  logic [pckg_sz-1:0]           D_push,
  input  logic                         rx_rd,
  output logic [pckg_sz-1:0]           rx_data,
  output logic                         rx_valid,
  output logic                         rx_empty,
  output logic                         rx_ovf,
  output logic [$clog2(depth+1)-1:0]   tx_count,
  output logic [$clog2(depth+1)-1:0]   rx_count
);

  logic tx_empty;
  logic tx_rd_en, tx_wr_en;
  logic rx_full;
  logic rx_rd_en, rx_wr_en;
  logic push_ok;
  logic [pckg_sz-1:0] rx_head;

`ifdef ADDR_CHECK_EN
  logic [PKT_MAX-1:0] push_ext;
  logic [ID_W-1:0]    push_dest;
  assign push_ext  = PKT_MAX'(D_push);
  assign push_dest = dest_of(push_ext, pckg_sz);
  assign push_ok   = (push_dest == id) || (push_dest == bc);
`else
  logic unused_cfg;
  assign unused_cfg = ^{id, bc};
  assign push_ok    = 1'b1;
`endif

  assign pndng = !tx_empty;

  // A pop in the same cycle frees the slot, so a write to a full FIFO still lands.
  assign tx_rd_en = pop && pndng;
  assign tx_wr_en = tx_wr && (!tx_full || tx_rd_en);
  assign rx_rd_en = rx_rd && !rx_empty;
  assign rx_wr_en = push && push_ok && (!rx_full || rx_rd_en);

  bus_term_fifo #(.width(pckg_sz), .depth(depth)) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr      (tx_wr_en),
    .wr_data (tx_data),
    .rd      (tx_rd_en),
    .full    (tx_full),
    .empty   (tx_empty),
    .count   (tx_count),
    .head    (D_pop)
  );

  bus_term_fifo #(.width(pckg_sz), .depth(depth)) u_rx_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr      (rx_wr_en),
    .wr_data (D_push),
    .rd      (rx_rd_en),
    .full    (rx_full),
    .empty   (rx_empty),
    .count   (rx_count),
    .head    (rx_head)
  );

  // Error flags are sticky until reset; rx_data holds the last packet read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_ovf   <= 1'b0;
      tx_unf   <= 1'b0;
      rx_ovf   <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      if (tx_wr && tx_full && !pop)                 tx_ovf <= 1'b1;
      if (pop && !pndng)                            tx_unf <= 1'b1;
      if (push && push_ok && rx_full && !rx_rd)     rx_ovf <= 1'b1;
      if (rx_rd_en) rx_data <= rx_head;
      rx_valid <= rx_rd_en;
    end
  end

endmodule

// File: tb/tb_bus_terminal_fifo.sv
// Scoreboard bench for bus_terminal_fifo (depth 8, 16-bit packets, id 3).
module tb_bus_terminal_fifo;

  localparam int W  = 16;
  localparam int D  = 8;
  localparam int CW = $clog2(D+1);
`ifdef ADDR_CHECK_EN
  localparam logic [7:0] RX_DST = 8'h03;
`else
  localparam logic [7:0] RX_DST = 8'h00;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          tx_wr = 1'b0;
  logic [W-1:0]  tx_data = '0;
  logic          tx_full, tx_ovf, pndng, tx_unf;
  logic [W-1:0]  D_pop;
  logic          pop = 1'b0;
  logic          push = 1'b0;
  logic [W-1:0]  D_push = '0;
  logic          rx_rd = 1'b0;
  logic [W-1:0]  rx_data;
  logic          rx_valid, rx_empty, rx_ovf;
  logic [CW-1:0] tx_count, rx_count;

  always #5 clk = ~clk;

  bus_terminal_fifo #(.pckg_sz(W), .depth(D), .id(8'h03), .bc(8'hFF)) dut (
    .clk(clk), .reset(reset),
    .tx_wr(tx_wr), .tx_data(tx_data), .tx_full(tx_full), .tx_ovf(tx_ovf),
    .pndng(pndng), .D_pop(D_pop), .pop(pop), .tx_unf(tx_unf),
    .push(push), .D_push(D_push), .rx_rd(rx_rd), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_empty(rx_empty), .rx_ovf(rx_ovf),
    .tx_count(tx_count), .rx_count(rx_count)
  );

  int total = 0;
  int bad = 0;
  logic [W-1:0] tx_q[$];
  logic [W-1:0] rx_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pndng"},    32'(pndng),    32'(0));
    check({tag, "_tx_full"},  32'(tx_full),  32'(0));
    check({tag, "_rx_empty"}, 32'(rx_empty), 32'(1));
    check({tag, "_D_pop"},    32'(D_pop),    32'(0));
    check({tag, "_rx_data"},  32'(rx_data),  32'(0));
    check({tag, "_rx_valid"}, 32'(rx_valid), 32'(0));
    check({tag, "_flags"},    32'({tx_ovf, tx_unf, rx_ovf}), 32'(0));
    check({tag, "_counts"},   32'({tx_count, rx_count}), 32'(0));
  endtask

  function automatic logic accepted(input logic [W-1:0] d);
`ifdef ADDR_CHECK_EN
    return (d[W-1 -: 8] == 8'h03) || (d[W-1 -: 8] == 8'hFF);
`else
    return 1'b1;
`endif
  endfunction

  task automatic tx_write(input logic [W-1:0] d);
    tx_wr = 1'b1; tx_data = d;
    step();
    tx_wr = 1'b0;
    if (tx_q.size() < D) tx_q.push_back(d);
  endtask

  task automatic tx_pop();
    logic [W-1:0] exp;
    exp = tx_q.pop_front();
    check("tx_pndng_before_pop", 32'(pndng), 32'(1));
    check("tx_D_pop", 32'(D_pop), 32'(exp));
    pop = 1'b1;
    step();
    pop = 1'b0;
  endtask

  task automatic bus_push(input logic [W-1:0] d);
    push = 1'b1; D_push = d;
    step();
    push = 1'b0;
    if (accepted(d) && rx_q.size() < D) rx_q.push_back(d);
  endtask

  task automatic host_read();
    logic [W-1:0] exp;
    exp = rx_q.pop_front();
    rx_rd = 1'b1;
    step();
    rx_rd = 1'b0;
    check("rx_valid_pulse", 32'(rx_valid), 32'(1));
    check("rx_data", 32'(rx_data), 32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] exp;

    // Reset state
    repeat (2) step();
    check_reset_state("reset");
    reset = 1'b1;
    step();

    // Basic TX: four packets, FWFT order
    for (int i = 1; i <= 4; i++) tx_write(W'(16'h0100 + i));
    check("tx_pndng_4", 32'(pndng), 32'(1));
    check("tx_D_pop_4", 32'(D_pop), 32'h0101);
    check("tx_count_4", 32'(tx_count), 32'(4));
    while (tx_q.size() > 0) tx_pop();
    check("tx_pndng_drained", 32'(pndng), 32'(0));

    // TX overflow: nine writes into depth eight
    for (int i = 0; i < 8; i++) tx_write(W'(16'h1000 + i));
    check("tx_full_after_8", 32'(tx_full), 32'(1));
    check("tx_ovf_before_9", 32'(tx_ovf), 32'(0));
    tx_write(16'h1008);
    check("tx_ovf_after_9", 32'(tx_ovf), 32'(1));
    check("tx_count_after_9", 32'(tx_count), 32'(8));
    while (tx_q.size() > 0) tx_pop();

    // TX underflow, then empty + write + pop in one cycle
    pop = 1'b1;
    step();
    pop = 1'b0;
    check("tx_unf", 32'(tx_unf), 32'(1));
    check("tx_count_unf", 32'(tx_count), 32'(0));
    tx_wr = 1'b1; pop = 1'b1; tx_data = 16'hBEEF;
    step();
    tx_wr = 1'b0; pop = 1'b0;
    tx_q.push_back(16'hBEEF);
    check("tx_count_empty_wr_pop", 32'(tx_count), 32'(1));
    tx_pop();

    // Full TX + write + pop in one cycle: both happen, count stays full
    for (int i = 0; i < 8; i++) tx_write(W'(16'h2000 + i));
    check("tx_D_pop_full", 32'(D_pop), 32'(tx_q[0]));
    void'(tx_q.pop_front());
    tx_q.push_back(16'h2100);
    tx_wr = 1'b1; pop = 1'b1; tx_data = 16'h2100;
    step();
    tx_wr = 1'b0; pop = 1'b0;
    check("tx_count_full_wr_pop", 32'(tx_count), 32'(8));
    check("tx_full_wr_pop", 32'(tx_full), 32'(1));
    while (tx_q.size() > 0) tx_pop();

    // Basic RX with one-cycle rx_valid pulses
    bus_push({RX_DST, 8'hAA});
    bus_push({RX_DST, 8'hBB});
    host_read();
    step();
    check("rx_valid_drop", 32'(rx_valid), 32'(0));
    host_read();
    step();
    check("rx_empty_after_reads", 32'(rx_empty), 32'(1));
    check("rx_valid_idle", 32'(rx_valid), 32'(0));

    // Full RX + push + read in one cycle
    for (int i = 0; i < 8; i++) bus_push({RX_DST, 8'(8'h40 + i)});
    check("rx_count_full", 32'(rx_count), 32'(8));
    exp = rx_q.pop_front();
    rx_q.push_back({RX_DST, 8'h50});
    push = 1'b1; rx_rd = 1'b1; D_push = {RX_DST, 8'h50};
    step();
    push = 1'b0; rx_rd = 1'b0;
    check("rx_count_push_rd", 32'(rx_count), 32'(8));
    check("rx_ovf_push_rd", 32'(rx_ovf), 32'(0));
    check("rx_valid_push_rd", 32'(rx_valid), 32'(1));
    check("rx_data_push_rd", 32'(rx_data), 32'(exp));

    // RX overflow: push while full without a read
    bus_push({RX_DST, 8'h5F});
    check("rx_ovf", 32'(rx_ovf), 32'(1));
    check("rx_count_ovf", 32'(rx_count), 32'(8));
    while (rx_q.size() > 0) host_read();

    // Wrap: twenty packets through the RX FIFO, order preserved
    for (int i = 0; i < 20; i++) begin
      bus_push({RX_DST, 8'(8'h60 + i)});
      if (rx_q.size() >= 5) host_read();
    end
    while (rx_q.size() > 0) host_read();
    check("rx_empty_after_wrap", 32'(rx_empty), 32'(1));

`ifdef ADDR_CHECK_EN
    // Address filter: only own ID and broadcast are stored, no overflow flag
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    bus_push(16'h0311);
    bus_push(16'h0522);
    bus_push(16'hFF33);
    check("addr_rx_count", 32'(rx_count), 32'(2));
    check("addr_rx_ovf", 32'(rx_ovf), 32'(0));
    host_read();
    host_read();
`endif

    // Reset asserted mid-burst clears everything asynchronously
    tx_write(16'h7001);
    tx_wr = 1'b1; push = 1'b1; tx_data = 16'h7002; D_push = {RX_DST, 8'h70};
    step();
    #2;
    reset = 1'b0;
    #1;
    check_reset_state("midreset");
    tx_wr = 1'b0; push = 1'b0;
    step();
    check_reset_state("midreset_held");
    reset = 1'b1;
    tx_q.delete();
    rx_q.delete();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
